pp_carry_accum_shift_reg: RTL and testbench
===========================================

Name: pp_carry_accum_shift_reg

Overview:
Parametrised carry-save partial-product / carry shift register for the Booth-encoded sequential multiplier. Each accepted row retires DIGIT result bits and shifts them into the low half. Adds what the fixed radix-16 store lacks: radix width as a parameter, a row handshake, a step counter and control FSM, signed/unsigned sign extension, abort, and a registered final carry-propagate resolve to a 2*WIDTH product.

Parameters:
WIDTH, 32, operand width; WIDTH % DIGIT == 0 required (elaboration assertion).
DIGIT, 4, bits retired per step (radix 2^DIGIT); legal range 2..8.
STEPS, WIDTH/DIGIT, derived localparam; rows per product.
ROW_W, WIDTH+DIGIT-1, derived localparam; width of each incoming sum/carry row.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin new product; honoured only in IDLE
signed_mode  in  1  sampled with start; 1 = sign-extend sum row, 0 = zero-extend
abort  in  1  synchronous return to IDLE from any state
row_valid  in  1  row_sum/row_carry valid
row_ready  out  1  high in ACCUM only
row_sum  in  ROW_W  CSA sum row for this step
row_carry  in  ROW_W  CSA carry row for this step
sum_dout  out  2*WIDTH  current sum register
carry_dout  out  2*WIDTH  current carry register
busy  out  1  state != IDLE
out_valid  out  1  high in DONE
out_ready  in  1  consumer accepts product
product  out  2*WIDTH  registered sum_q + carry_q (mod 2^(2*WIDTH))

Behaviour:
- Reset: state IDLE, sum_q = carry_q = product_q = 0, cnt = 0, sgn_q = 0; row_ready/out_valid/busy = 0.
- FSM states: IDLE, ACCUM, RESOLVE, DONE.
- IDLE: when start=1, clear sum_q, carry_q and cnt, latch sgn_q <= signed_mode, and go to ACCUM. product_q holds its last value.
- ACCUM: row_ready=1. On each row_valid & row_ready:
  - sum_q <= {ext, row_sum, sum_q[WIDTH-1:DIGIT]}, where ext = sgn_q & row_sum[ROW_W-1].
  - carry_q <= {row_carry, 1'b0, carry_q[WIDTH-1:DIGIT]}. The carry row is therefore one bit more significant.
  - cnt++.
  - On the acceptance that makes cnt == STEPS, go to RESOLVE.
  - No row_valid means a stall: registers and counter hold.
- RESOLVE: exactly one cycle. product_q <= sum_q + carry_q; then DONE.
- DONE: out_valid=1 and product stable until out_ready=1, then IDLE on the next edge. out_ready outside DONE is ignored.
- Latency: start at cycle t gives first possible row acceptance at t+1. With back-to-back rows, out_valid rises at t+STEPS+2.
- start while busy is ignored, with no effect on the state or the stored data.
- abort (priority over all other events): next edge goes to IDLE, clears sum_q/carry_q/cnt, and deasserts out_valid. A row presented in the same cycle is dropped.
- start and abort together in IDLE: abort wins and the block stays in IDLE.
- sum_dout/carry_dout are combinational copies of the registers.
- cnt width is $clog2(STEPS+1). It never exceeds STEPS.

Decomposition:
- mul_pkg additions: DIGIT constant, derived STEPS/ROW_W localparams, and the state enum typedef.
- One natural sub-module, pp_step_counter: load/clear/increment, terminal-count flag at STEPS.
- The adder is inline.

Test Plan (WIDTH=8, DIGIT=4, STEPS=2, ROW_W=11):
1. Unsigned: start; row1 sum=0x00A, carry=0; row2 sum=0x003, carry=0 -> after row1 sum_dout=0x00A0; after row2 0x003A; product=0x003A; out_valid at t+4.
2. Carry path: start; row1 sum=0, carry=0x001; row2 both 0 -> carry_dout=0x0020 after row1, 0x0002 after row2; product=0x0002.
3. Signed: signed_mode=1; rows sum=0x7FF twice -> sum_dout 0xFFF0 then 0xFFFF; product=0xFFFF. Same rows with signed_mode=0 -> product=0x7FFF.
4. Stalls/backpressure: row_valid low 3 cycles between rows -> cnt and registers hold. Hold out_ready low 5 cycles in DONE -> product/out_valid stable, start ignored, busy=1.
5. Abort: abort in the same cycle as the row1 acceptance -> IDLE next cycle, sum_dout=0, no out_valid. A following full run gives the correct product.
6. Reset mid-ACCUM: rst_n low after row1 -> all outputs 0 immediately (async), busy=0.

Source files
------------

// File: rtl/pp_carry_accum_shift_reg_pkg.sv
// Shared constants, control states and size helpers for the sequential
// Booth multiplier partial-product shift register.
package pp_carry_accum_shift_reg_pkg;

    localparam int unsigned PP_WIDTH = 32;
    localparam int unsigned PP_DIGIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } pp_state_e;

    function automatic int unsigned steps_f(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    function automatic int unsigned row_w_f(input int unsigned width, input int unsigned digit);
        return width + digit - 1;
    endfunction

endpackage

// File: rtl/pp_carry_accum_shift_reg_step_counter.sv
// Step counter: clear, saturating increment, and a flag that says the next
// increment retires the final row.
module pp_step_counter #(
    parameter int unsigned STEPS = 8,
    localparam int unsigned CNT_W = $clog2(STEPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             at_last_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STEPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Independent of inc_i so the FSM can use it without a combinational loop.
    assign at_last_o = (cnt_q == CNT_LAST);
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/pp_carry_accum_shift_reg.sv
// Carry-save partial-product / carry shift register with row handshake,
// step control and a registered carry-propagate resolve to a 2*WIDTH product.
module pp_carry_accum_shift_reg
    import pp_carry_accum_shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = PP_WIDTH,
    parameter int unsigned DIGIT = PP_DIGIT,
    localparam int unsigned STEPS = steps_f(WIDTH, DIGIT),
    localparam int unsigned ROW_W = row_w_f(WIDTH, DIGIT),
    localparam int unsigned CNT_W = $clog2(STEPS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic               abort,
    input  logic               row_valid,
    output logic               row_ready,
    input  logic [ROW_W-1:0]   row_sum,
    input  logic [ROW_W-1:0]   row_carry,
    output logic [2*WIDTH-1:0] sum_dout,
    output logic [2*WIDTH-1:0] carry_dout,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output pp_state_e          dbg_state,
    output logic [CNT_W-1:0]   dbg_cnt
);

    if ((WIDTH % DIGIT) != 0) begin : g_bad_width
        $error("WIDTH must be a multiple of DIGIT");
    end
    if ((DIGIT < 2) || (DIGIT > 8)) begin : g_bad_digit
        $error("DIGIT must lie in 2..8");
    end

    // Handshakes: a row transfers on a rising edge where row_valid && row_ready;
    // a product transfers where out_valid && out_ready. Both ready/valid are
    // state-derived (Moore), and abort overrides any transfer in its cycle.

    pp_state_e          state_q, state_d;
    logic [2*WIDTH-1:0] sum_q, sum_d;
    logic [2*WIDTH-1:0] carry_q, carry_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               sgn_q, sgn_d;
    logic               cnt_clr, cnt_inc, cnt_at_last;
    logic               ext;

    pp_step_counter #(
        .STEPS (STEPS)
    ) u_step_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (cnt_clr),
        .inc_i     (cnt_inc),
        .cnt_o     (dbg_cnt),
        .at_last_o (cnt_at_last)
    );

    assign ext = sgn_q & row_sum[ROW_W-1];

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        product_d = product_q;
        sgn_d     = sgn_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            sum_d   = '0;
            carry_d = '0;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_ACCUM;
                        sum_d   = '0;
                        carry_d = '0;
                        sgn_d   = signed_mode;
                        cnt_clr = 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (row_valid) begin
                        // Carry row sits one bit above the sum row.
                        sum_d   = {ext, row_sum, sum_q[WIDTH-1:DIGIT]};
                        carry_d = {row_carry, 1'b0, carry_q[WIDTH-1:DIGIT]};
                        cnt_inc = 1'b1;
                        if (cnt_at_last) begin
                            state_d = ST_RESOLVE;
                        end
                    end
                end
                ST_RESOLVE: begin
                    product_d = sum_q + carry_q;
                    state_d   = ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sum_q     <= '0;
            carry_q   <= '0;
            product_q <= '0;
            sgn_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            product_q <= product_d;
            sgn_q     <= sgn_d;
        end
    end

    assign row_ready  = (state_q == ST_ACCUM);
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign sum_dout   = sum_q;
    assign carry_dout = carry_q;
    assign product    = product_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pp_carry_accum_shift_reg.sv
// Directed bench for pp_carry_accum_shift_reg at WIDTH=8, DIGIT=4; products
// are checked by a queue-based monitor, register views by inline checks.
module tb_pp_carry_accum_shift_reg;
    import pp_carry_accum_shift_reg_pkg::*;

    localparam int WIDTH = 8;
    localparam int DIGIT = 4;
    localparam int ROW_W = 11;
    localparam int PW    = 16;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             signed_mode = 1'b0;
    logic             abort = 1'b0;
    logic             row_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [ROW_W-1:0] row_sum = '0;
    logic [ROW_W-1:0] row_carry = '0;
    logic             row_ready, busy, out_valid;
    logic [PW-1:0]    sum_dout, carry_dout, product;
    pp_state_e        dbg_state;
    logic [CNT_W-1:0] dbg_cnt;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            t0;
    logic [PW-1:0] exp_q[$];

    pp_carry_accum_shift_reg #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .abort       (abort),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .row_sum     (row_sum),
        .row_carry   (row_carry),
        .sum_dout    (sum_dout),
        .carry_dout  (carry_dout),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .dbg_state   (dbg_state),
        .dbg_cnt     (dbg_cnt)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scoreboard monitor: pops on every product transfer
    always @(negedge clk) begin
        logic [PW-1:0] e;
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL product_unexpected: got %h, none expected", product);
            end else begin
                e = exp_q.pop_front();
                if (product !== e) begin
                    n_errors++;
                    $display("FAIL product: got %h expected %h", product, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic sgn);
        start = 1'b1;
        signed_mode = sgn;
        t0 = cyc;
        tick();
        start = 1'b0;
        signed_mode = 1'b0;
    endtask

    task automatic send_row(input logic [ROW_W-1:0] s, input logic [ROW_W-1:0] c);
        row_valid = 1'b1;
        row_sum = s;
        row_carry = c;
        tick();
        row_valid = 1'b0;
        row_sum = '0;
        row_carry = '0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        check("out_valid_wait", 32'(out_valid), 32'd1);
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum", 32'(sum_dout), 32'h0);
        check("rst_carry", 32'(carry_dout), 32'h0);
        check("rst_product", 32'(product), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_row_ready", 32'(row_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        rst_n = 1'b1;
        tick();

        // 1: unsigned, latency
        exp_q.push_back(16'h003A);
        do_start(1'b0);
        check("t1_row_ready", 32'(row_ready), 32'h1);
        check("t1_busy", 32'(busy), 32'h1);
        send_row(11'h00A, 11'h000);
        check("t1_sum_r1", 32'(sum_dout), 32'h00A0);
        check("t1_cnt_r1", 32'(dbg_cnt), 32'd1);
        send_row(11'h003, 11'h000);
        check("t1_sum_r2", 32'(sum_dout), 32'h003A);
        check("t1_state_resolve", 32'(dbg_state), 32'(ST_RESOLVE));
        check("t1_no_valid_yet", 32'(out_valid), 32'h0);
        tick();
        check("t1_out_valid", 32'(out_valid), 32'h1);
        check("t1_latency", 32'(cyc - t0), 32'd4);
        check("t1_product", 32'(product), 32'h003A);
        accept_out();
        check("t1_idle", 32'(busy), 32'h0);

        // 2: carry path
        exp_q.push_back(16'h0002);
        do_start(1'b0);
        send_row(11'h000, 11'h001);
        check("t2_carry_r1", 32'(carry_dout), 32'h0020);
        check("t2_sum_r1", 32'(sum_dout), 32'h0000);
        send_row(11'h000, 11'h000);
        check("t2_carry_r2", 32'(carry_dout), 32'h0002);
        wait_done(10);
        accept_out();

        // 3: signed vs unsigned extension
        exp_q.push_back(16'hFFFF);
        do_start(1'b1);
        send_row(11'h7FF, 11'h000);
        check("t3s_sum_r1", 32'(sum_dout), 32'hFFF0);
        send_row(11'h7FF, 11'h000);
        check("t3s_sum_r2", 32'(sum_dout), 32'hFFFF);
        wait_done(10);
        accept_out();
        exp_q.push_back(16'h7FFF);
        do_start(1'b0);
        send_row(11'h7FF, 11'h000);
        check("t3u_sum_r1", 32'(sum_dout), 32'h7FF0);
        send_row(11'h7FF, 11'h000);
        check("t3u_sum_r2", 32'(sum_dout), 32'h7FFF);
        wait_done(10);
        accept_out();

        // 4: row stalls and output backpressure
        exp_q.push_back(16'h00E9);
        do_start(1'b0);
        send_row(11'h005, 11'h002);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_stall_sum", 32'(sum_dout), 32'h0050);
            check("t4_stall_carry", 32'(carry_dout), 32'h0040);
            check("t4_stall_cnt", 32'(dbg_cnt), 32'd1);
            check("t4_stall_state", 32'(dbg_state), 32'(ST_ACCUM));
        end
        send_row(11'h00C, 11'h001);
        check("t4_sum_r2", 32'(sum_dout), 32'h00C5);
        check("t4_carry_r2", 32'(carry_dout), 32'h0024);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) start = 1'b1;
            tick();
            start = 1'b0;
            check("t4_hold_valid", 32'(out_valid), 32'h1);
            check("t4_hold_product", 32'(product), 32'h00E9);
            check("t4_hold_busy", 32'(busy), 32'h1);
            check("t4_hold_sum", 32'(sum_dout), 32'h00C5);
        end
        accept_out();
        check("t4_idle", 32'(dbg_state), 32'(ST_IDLE));

        // 5: abort with a concurrent row, then start+abort in IDLE, then a clean run
        do_start(1'b0);
        row_valid = 1'b1;
        row_sum = 11'h00A;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        row_valid = 1'b0;
        row_sum = '0;
        check("t5_abort_busy", 32'(busy), 32'h0);
        check("t5_abort_sum", 32'(sum_dout), 32'h0);
        check("t5_abort_cnt", 32'(dbg_cnt), 32'd0);
        repeat (3) tick();
        check("t5_abort_no_valid", 32'(out_valid), 32'h0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("t5_start_abort_idle", 32'(busy), 32'h0);
        exp_q.push_back(16'h003A);
        do_start(1'b0);
        send_row(11'h00A, 11'h000);
        send_row(11'h003, 11'h000);
        wait_done(10);
        check("t5_rerun_product", 32'(product), 32'h003A);
        accept_out();

        // 6: asynchronous reset mid-accumulation
        do_start(1'b0);
        send_row(11'h00A, 11'h000);
        check("t6_sum_r1", 32'(sum_dout), 32'h00A0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_sum", 32'(sum_dout), 32'h0);
        check("t6_rst_carry", 32'(carry_dout), 32'h0);
        check("t6_rst_product", 32'(product), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_row_ready", 32'(row_ready), 32'h0);
        check("t6_rst_out_valid", 32'(out_valid), 32'h0);
        check("t6_rst_cnt", 32'(dbg_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t6_post_idle", 32'(busy), 32'h0);

        // Final report
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
